// File: rtl/bram_arb_pkg.sv
//==============================================================================
// bram_arb_pkg : shared FSM state type and BRAM latency for bram_burst_arbiter
// Rev 1.0
//==============================================================================
`default_nettype none

package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int BRAM_READ_LATENCY = 2;

endpackage

`default_nettype wire

// File: rtl/bram_burst_arbiter_if.sv
//==============================================================================
// bram_burst_arbiter_if : requester/BRAM bus of the burst arbiter
// Rev 1.0
//==============================================================================
`default_nettype none

interface bram_burst_arbiter_if #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int NUM_SLOTS     = 4
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int BLK_W  = $clog2(NUM_BLOCKS);
  localparam int ADDR_W = SLOT_W + BLK_W;

  logic [1:0]               req_in;
  logic [2*SLOT_W-1:0]      req_slot_in;
  logic [1:0]               grant_out;
  logic                     busy_out;
  logic [ADDR_W-1:0]        bram_addr_out;
  logic [REGISTER_SIZE-1:0] bram_data_in;
  logic [REGISTER_SIZE-1:0] data_out;
  logic [1:0]               data_valid_out;
  logic                     data_last_out;

  modport master (
    output req_in, req_slot_in, bram_data_in,
    input  grant_out, busy_out, bram_addr_out, data_out, data_valid_out, data_last_out
  );

  modport slave (
    input  req_in, req_slot_in, bram_data_in,
    output grant_out, busy_out, bram_addr_out, data_out, data_valid_out, data_last_out
  );

endinterface

`default_nettype wire

// File: rtl/bram_burst_arbiter_rr_arbiter2.sv
//==============================================================================
// rr_arbiter2 : two-input round-robin pick; BURST_ARB_FIXED_PRIORITY_EN makes
// requester 0 always win. Rev 1.0
//==============================================================================
`default_nettype none

module rr_arbiter2 (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] i_req,
  input  wire logic       i_update,
  input  wire logic [1:0] i_won,
  output logic [1:0]      o_pick
);

`ifdef BURST_ARB_FIXED_PRIORITY_EN
  wire w_unused = &{1'b0, clk, rst, i_update, i_won};

  always_comb begin
    o_pick = 2'b00;
    if (i_req[0]) begin
      o_pick = 2'b01;
    end else if (i_req[1]) begin
      o_pick = 2'b10;
    end
  end
`else
  // r_ptr names the requester preferred on a tie
  logic r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_update) begin
      r_ptr <= i_won[0];
    end
  end

  always_comb begin
    o_pick = 2'b00;
    case (i_req)
      2'b01:   o_pick = 2'b01;
      2'b10:   o_pick = 2'b10;
      2'b11:   o_pick = r_ptr ? 2'b10 : 2'b01;
      default: o_pick = 2'b00;
    endcase
  end
`endif

endmodule

`default_nettype wire

// File: rtl/evt_counter.sv
//==============================================================================
// evt_counter : modulo-MAX_COUNT event counter with clear and wrap strobe
// Rev 1.0
//==============================================================================
`default_nettype none

module evt_counter #(
  parameter  int MAX_COUNT = 128,
  localparam int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clr,
  input  wire logic             i_en,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_wrap
);

  logic [CNT_W-1:0] r_count;

  assign o_wrap  = i_en && (r_count == CNT_W'(MAX_COUNT - 1));
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_burst_arbiter.sv
//==============================================================================
// bram_burst_arbiter : shares one BRAM read port between two burst requesters,
// hiding read latency. Option: BURST_ARB_FIXED_PRIORITY_EN. Rev 1.0
//==============================================================================
`default_nettype none

module bram_burst_arbiter
  import bram_arb_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int NUM_SLOTS     = 4
) (
  input  wire logic           clk_in,
  input  wire logic           rst_in,
  bram_burst_arbiter_if.slave bus
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int BLK_W  = $clog2(NUM_BLOCKS);
  localparam int DRN_W  = $clog2(BRAM_READ_LATENCY + 1);

  arb_state_t         r_state;
  logic [1:0]         r_grant;
  logic               r_busy;
  logic [SLOT_W-1:0]  r_slot;
  logic [DRN_W-1:0]   r_drain_cnt;
  logic [1:0]         r_vpipe [BRAM_READ_LATENCY];
  logic [BRAM_READ_LATENCY-1:0] r_lpipe;

  logic [BLK_W-1:0]   w_blk_idx;
  logic               w_blk_wrap;
  logic               w_issue;
  logic               w_drain_done;
  logic [1:0]         w_pick;
  logic [SLOT_W-1:0]  w_win_slot;
  logic [1:0]         w_valid;
  logic [REGISTER_SIZE-1:0] w_data;

  assign w_issue      = (r_state == ISSUE);
  assign w_drain_done = (r_state == DRAIN) && (r_drain_cnt == DRN_W'(BRAM_READ_LATENCY - 1));
  assign w_win_slot   = w_pick[1] ? bus.req_slot_in[SLOT_W +: SLOT_W]
                                  : bus.req_slot_in[0 +: SLOT_W];

  rr_arbiter2 u_arb (
    .clk      (clk_in),
    .rst      (rst_in),
    .i_req    (bus.req_in),
    .i_update (w_drain_done),
    .i_won    (r_grant),
    .o_pick   (w_pick)
  );

  evt_counter #(
    .MAX_COUNT (NUM_BLOCKS)
  ) u_blk_cnt (
    .clk     (clk_in),
    .rst     (rst_in),
    .i_clr   (~w_issue),
    .i_en    (w_issue),
    .o_count (w_blk_idx),
    .o_wrap  (w_blk_wrap)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_grant     <= 2'b00;
      r_busy      <= 1'b0;
      r_slot      <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|bus.req_in) begin
            r_state <= ISSUE;
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_slot  <= w_win_slot;
          end
        end
        ISSUE: begin
          if (w_blk_wrap) begin
            r_state     <= DRAIN;
            r_drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (w_drain_done) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // valid/last travel alongside the BRAM read so they line up with its data
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < BRAM_READ_LATENCY; i++) begin
        r_vpipe[i] <= 2'b00;
      end
      r_lpipe <= '0;
    end else begin
      r_vpipe[0] <= w_issue ? r_grant : 2'b00;
      r_lpipe[0] <= w_blk_wrap;
      for (int i = 1; i < BRAM_READ_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_lpipe[i] <= r_lpipe[i-1];
      end
    end
  end

  assign w_valid = r_vpipe[BRAM_READ_LATENCY-1];
  assign w_data  = (|w_valid) ? bus.bram_data_in : '0;

  assign bus.grant_out      = r_grant;
  assign bus.busy_out       = r_busy;
  assign bus.bram_addr_out  = w_issue ? {r_slot, w_blk_idx} : '0;
  assign bus.data_out       = w_data;
  assign bus.data_valid_out = w_valid;
  assign bus.data_last_out  = r_lpipe[BRAM_READ_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_bram_burst_arbiter.sv
//==============================================================================
// tb_bram_burst_arbiter : directed + randomized bench with a burst-level model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_bram_burst_arbiter;

  localparam int RS = 32;
  localparam int NB = 4;
  localparam int NS = 4;

  logic clk_in;
  logic rst_in;

  int n_tests;
  int n_fail;
  int m_ptr;

  logic [RS-1:0] mem [NB*NS];
  logic [RS-1:0] r_d1;
  logic [RS-1:0] r_d2;

  bram_burst_arbiter_if #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .NUM_SLOTS(NS)) bus ();

  bram_burst_arbiter #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .NUM_SLOTS(NS)) u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // two-cycle BRAM
  always @(posedge clk_in) begin
    r_d1 <= mem[bus.bram_addr_out];
    r_d2 <= r_d1;
  end
  assign bus.bram_data_in = r_d2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] r, input int ptr);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
`ifdef BURST_ARB_FIXED_PRIORITY_EN
    return 0;
`else
    return ptr;
`endif
  endfunction

  // Call with the request for decision cycle T already driven; returns inside T+NB+3.
  task automatic run_burst(input int mode);
    int w;
    int slot;
    logic [1:0] oh;
    logic [3:0] slots;
    w     = pick(bus.req_in, m_ptr);
    slots = bus.req_slot_in;
    slot  = (w == 1) ? int'(slots[3:2]) : int'(slots[1:0]);
    oh    = 2'(1 << w);
    for (int c = 1; c <= NB + 3; c++) begin
      @(posedge clk_in);
      #1;
      if (mode == 1 && c <= NB + 2) begin
        bus.req_in      = 2'($urandom_range(0, 3));
        bus.req_slot_in = 4'($urandom);
      end
      if (mode == 2 && c == 2) begin
        bus.req_in           = 2'b11;
        bus.req_slot_in[1:0] = 2'(slot + 1);
      end
      @(negedge clk_in);
      chk($sformatf("grant c%0d", c), 64'(bus.grant_out), (c <= NB + 2) ? 64'(oh) : 64'd0);
      chk($sformatf("busy c%0d", c), 64'(bus.busy_out), (c <= NB + 2) ? 64'd1 : 64'd0);
      if (c <= NB)
        chk($sformatf("addr c%0d", c), 64'(bus.bram_addr_out), 64'(slot * NB + c - 1));
      chk($sformatf("valid c%0d", c), 64'(bus.data_valid_out),
          (c >= 3 && c <= NB + 2) ? 64'(oh) : 64'd0);
      chk($sformatf("last c%0d", c), 64'(bus.data_last_out), (c == NB + 2) ? 64'd1 : 64'd0);
      if (c >= 3 && c <= NB + 2)
        chk($sformatf("data c%0d", c), 64'(bus.data_out), 64'(mem[slot * NB + c - 3]));
    end
`ifndef BURST_ARB_FIXED_PRIORITY_EN
    m_ptr = 1 - w;
`endif
  endtask

  task automatic idle_cycle();
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    chk("idle grant", 64'(bus.grant_out), 64'd0);
    chk("idle busy", 64'(bus.busy_out), 64'd0);
    chk("idle valid", 64'(bus.data_valid_out), 64'd0);
    chk("idle last", 64'(bus.data_last_out), 64'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ptr   = 0;
    rst_in  = 1'b1;
    bus.req_in      = 2'b00;
    bus.req_slot_in = 4'b0000;
    for (int i = 0; i < NB * NS; i++) mem[i] = $urandom;

    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst grant", 64'(bus.grant_out), 64'd0);
    chk("rst busy", 64'(bus.busy_out), 64'd0);
    chk("rst addr", 64'(bus.bram_addr_out), 64'd0);
    chk("rst valid", 64'(bus.data_valid_out), 64'd0);
    chk("rst last", 64'(bus.data_last_out), 64'd0);
    chk("rst data", 64'(bus.data_out), 64'd0);

    // simultaneous requests held for four bursts: slots 1 and 3
    bus.req_in      = 2'b11;
    bus.req_slot_in = {2'd3, 2'd1};
    repeat (4) run_burst(0);
    bus.req_in = 2'b00;
    idle_cycle();

    // single request for slot 2
    bus.req_in      = 2'b01;
    bus.req_slot_in = {2'd0, 2'd2};
    run_burst(0);
    bus.req_in = 2'b00;
    idle_cycle();

    // late arrival of requester 1 with a mid-burst slot change on requester 0
    bus.req_in      = 2'b01;
    bus.req_slot_in = {2'd1, 2'd0};
    run_burst(2);
    run_burst(0);
    bus.req_in = 2'b00;
    idle_cycle();

    // reset in the middle of a burst
    bus.req_in      = 2'b10;
    bus.req_slot_in = {2'd2, 2'd0};
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk_in);
      #1;
      if (c == 4) rst_in = 1'b1;
      @(negedge clk_in);
      if (c == 1) chk("mid grant", 64'(bus.grant_out), 64'd2);
      if (c == 3) chk("mid valid", 64'(bus.data_valid_out), 64'd2);
    end
    @(posedge clk_in);
    #1;
    rst_in     = 1'b0;
    bus.req_in = 2'b00;
    @(negedge clk_in);
    chk("mrst grant", 64'(bus.grant_out), 64'd0);
    chk("mrst busy", 64'(bus.busy_out), 64'd0);
    chk("mrst addr", 64'(bus.bram_addr_out), 64'd0);
    chk("mrst valid", 64'(bus.data_valid_out), 64'd0);
    chk("mrst last", 64'(bus.data_last_out), 64'd0);
    chk("mrst data", 64'(bus.data_out), 64'd0);
    m_ptr = 0;
    repeat (4) idle_cycle();

    bus.req_in      = 2'b11;
    bus.req_slot_in = 4'($urandom);
    run_burst(0);

    // randomized traffic with requests/slots churning during bursts
    for (int k = 0; k < 24; k++) begin
      bus.req_in      = 2'($urandom_range(0, 3));
      bus.req_slot_in = 4'($urandom);
      if (bus.req_in == 2'b00) idle_cycle();
      else run_burst(1);
    end
    bus.req_in = 2'b00;
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
